// File: rtl/mux4to1_rr_stream.sv
// Four-channel round-robin arbitrated multiplexer feeding one registered output stream.
// Define MUX4_STATS_EN to add saturating per-channel grant counters on grant_cnt_o.
module mux4to1_rr_stream #(
  parameter int unsigned DATA_W = 8
`ifdef MUX4_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          in_valid_i,
  input  logic [4*DATA_W-1:0] in_data_i,
  output logic [3:0]          in_ready_o,
  output logic                out_valid_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [1:0]          out_sel_o,
`ifdef MUX4_STATS_EN
  input  logic                out_ready_i,
  output logic [4*CNT_W-1:0]  grant_cnt_o
`else
  input  logic                out_ready_i
`endif
);

  typedef enum logic {
    StEmpty,
    StFull
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  logic              advance;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;

  // Rotating priority scan starting at rr_ptr_q; in_data never feeds this path.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!grant_vld && in_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign advance = (state_q == StEmpty) || out_ready_i;

  always_comb begin
    in_ready_o = 4'b0000;
    if (rst_ni && advance && grant_vld) begin
      in_ready_o[grant_idx] = 1'b1;
    end
  end

  // A drain and a new load share the same edge, so a full pipe never bubbles.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      if (grant_vld) begin
        state_d  = StFull;
        sel_d    = grant_idx;
        rr_ptr_d = grant_idx + 2'd1;
        for (int i = 0; i < 4; i++) begin
          if (grant_idx == 2'(i)) begin
            data_d = in_data_i[i*DATA_W +: DATA_W];
          end
        end
      end else begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      sel_q    <= 2'b00;
      rr_ptr_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid_o = (state_q == StFull);
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;

`ifdef MUX4_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_valid_i[i] && in_ready_o[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < 4; i++) begin
      grant_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mux4to1_rr_stream.sv
// Self-checking bench for mux4to1_rr_stream: directed literal checks plus randomized traffic
// compared every cycle against a queue-free behavioural model of the arbiter and output stage.
module tb_mux4to1_rr_stream;

  localparam int DW = 8;
`ifdef MUX4_STATS_EN
  localparam int CW = 4;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      in_valid = 4'b0000;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready = 1'b0;
`ifdef MUX4_STATS_EN
  logic [4*CW-1:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux4to1_rr_stream #(
    .DATA_W(DW)
`ifdef MUX4_STATS_EN
    ,
    .CNT_W (CW)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_sel_o  (out_sel),
`ifdef MUX4_STATS_EN
    .out_ready_i(out_ready),
    .grant_cnt_o(grant_cnt)
`else
    .out_ready_i(out_ready)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: output register contents, next-start channel, grant counts.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_sel = 0;
  int            m_ptr = 0;
  int            m_cnt [4] = '{0, 0, 0, 0};
  logic [3:0]    last_acc = 4'b0000;

  // Granted channel = requester at the smallest forward distance from the start pointer.
  function automatic int pick(input logic [3:0] v, input int ptr);
    int best = -1;
    int bestd = 4;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        int d = (i - ptr + 4) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (!rst_n) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    g = pick(in_valid, m_ptr);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  always @(posedge clk) begin
    int g;
    last_acc = exp_ready();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (!m_valid || out_ready) begin
      g = pick(in_valid, m_ptr);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*DW +: DW];
        m_sel   = g;
        m_ptr   = (g + 1) % 4;
`ifdef MUX4_STATS_EN
        if (m_cnt[g] < (1 << CW) - 1) m_cnt[g] = m_cnt[g] + 1;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_sel", 64'(out_sel), 64'(m_sel));
    check("in_ready", 64'(in_ready), 64'(exp_ready()));
`ifdef MUX4_STATS_EN
    for (int i = 0; i < 4; i++) begin
      check("grant_cnt", 64'(grant_cnt[i*CW +: CW]), 64'(m_cnt[i]));
    end
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [DW-1:0] w);
    in_data[ch*DW +: DW] = w;
  endtask

  int t3_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int rdy_pct;

  initial begin
    // T1: reset with all channels requesting
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i));
    repeat (2) begin
      cyc();
      @(negedge clk);
      check("t1_in_ready", 64'(in_ready), 64'h0);
      check("t1_out_valid", 64'(out_valid), 64'h0);
      check("t1_out_sel", 64'(out_sel), 64'h0);
    end

    // T3: full load rotates 0,1,2,3 with no bubbles
    rst_n = 1'b1;
    #1;
    check("t3_first_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge clk);
      check("t3_out_valid", 64'(out_valid), 64'h1);
      check("t3_out_sel", 64'(out_sel), 64'(t3_exp[i]));
    end

    // T2: single requester on channel 2
    rst_n = 1'b0;
    cyc();
    rst_n    = 1'b1;
    in_valid = 4'b0100;
    set_word(2, 8'hA5);
    @(negedge clk);
    check("t2_in_ready", 64'(in_ready), 64'h4);
    cyc();
    in_valid = 4'b0000;
    @(negedge clk);
    check("t2_out_valid", 64'(out_valid), 64'h1);
    check("t2_out_data", 64'(out_data), 64'hA5);
    check("t2_out_sel", 64'(out_sel), 64'h2);

    // T4: stall with channel 1 held, then release
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    set_word(0, 8'h11);
    set_word(1, 8'h3C);
    set_word(2, 8'h5A);
    set_word(3, 8'h77);
    cyc();
    in_valid = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(in_ready), 64'h0);
      check("t4_stall_valid", 64'(out_valid), 64'h1);
      check("t4_stall_sel", 64'(out_sel), 64'h1);
      check("t4_stall_data", 64'(out_data), 64'h3C);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_ready", 64'(in_ready), 64'h4);
    cyc();
    @(negedge clk);
    check("t4_next_sel", 64'(out_sel), 64'h2);
    check("t4_next_data", 64'(out_data), 64'h5A);

    // T5: reset in the middle of a stream
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check("t5_reset_valid", 64'(out_valid), 64'h0);
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    check("t5_first_valid", 64'(out_valid), 64'h1);
    check("t5_first_sel", 64'(out_sel), 64'h0);

`ifdef MUX4_STATS_EN
    // T6: counter saturation on channel 3
    rst_n = 1'b0;
    cyc();
    rst_n    = 1'b1;
    in_valid = 4'b1000;
    repeat (20) cyc();
    @(negedge clk);
    check("t6_cnt3", 64'(grant_cnt[3*CW +: CW]), 64'hF);
    check("t6_cnt0", 64'(grant_cnt[0 +: CW]), 64'h0);
    check("t6_cnt1", 64'(grant_cnt[CW +: CW]), 64'h0);
    check("t6_cnt2", 64'(grant_cnt[2*CW +: CW]), 64'h0);
`endif

    // Randomized traffic; producers hold valid/data until accepted.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      rdy_pct = 20 + 15 * blk;
      repeat (500) begin
        cyc();
        rst_n     = ($urandom_range(0, 299) != 0);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int ch = 0; ch < 4; ch++) begin
          if (!in_valid[ch] || last_acc[ch]) begin
            in_valid[ch] = ($urandom_range(0, 99) < 55);
            set_word(ch, 8'($urandom));
          end
        end
      end
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
